// File: rtl/fetch_unit.sv
// Pipelined instruction-fetch front end: credit-limited imem requests, in-order
// responses into a prefetch FIFO, valid/ready toward decode, redirect with flush.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o,
  input  logic               redirect_i,
  input  logic [1:0]         redirect_mode_i,
  input  logic [ADDR_W-1:0]  redirect_base_i,
  input  logic [25:0]        redirect_imm_i,
  input  logic [ADDR_W-1:0]  redirect_reg_i
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [CW-1:0]      cnt_q, cnt_d, out_q, out_d, drop_q, drop_d;
  logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d, fwr_q, fwr_d, frd_q, frd_d;
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [ADDR_W-1:0]  ipc_mem_q   [DEPTH];
  logic [ADDR_W-1:0]  fpc_mem_q   [DEPTH];

  logic [ADDR_W-1:0]  pc4, br_tgt, jmp_tgt, reg_tgt, tgt;
  logic [CW:0]        credit;
  logic               issue, push, pop;

  assign pc4     = redirect_base_i + ADDR_W'(4);
  assign br_tgt  = pc4 + {{(ADDR_W-18){redirect_imm_i[15]}}, redirect_imm_i[15:0], 2'b00};
  assign reg_tgt = redirect_reg_i & ~ADDR_W'(3);

  generate
    if (ADDR_W > 28) begin : g_jmp_hi
      assign jmp_tgt = {pc4[ADDR_W-1:28], redirect_imm_i, 2'b00};
    end else begin : g_jmp_lo
      assign jmp_tgt = {redirect_imm_i, 2'b00};
    end
  endgenerate

  always_comb begin
    case (redirect_mode_i)
      2'b00:   tgt = br_tgt;
      2'b01:   tgt = jmp_tgt;
      default: tgt = reg_tgt;
    endcase
  end

  // Outstanding requests hold a FIFO slot in reserve, so a push can never overflow.
  assign credit        = {1'b0, cnt_q} + {1'b0, out_q};
  assign issue         = !rst_i && !redirect_i && (credit < (CW+1)'(DEPTH));
  assign instr_valid_o = (cnt_q != '0);
  assign pop           = instr_valid_o && instr_ready_i;
  assign push          = imem_rvalid_i && !redirect_i && (drop_q == '0);

  assign imem_req_o  = issue;
  assign imem_addr_o = pc_q;
  assign instr_o     = instr_valid_o ? instr_mem_q[rd_q] : '0;
  assign instr_pc_o  = instr_valid_o ? ipc_mem_q[rd_q]   : '0;

  always_comb begin
    pc_d = pc_q;
    if (redirect_i)  pc_d = tgt;
    else if (issue)  pc_d = pc_q + ADDR_W'(4);

    out_d = out_q + CW'(issue) - CW'(imem_rvalid_i);

    // Every response still owed to the old stream must be thrown away.
    drop_d = drop_q;
    if (redirect_i)                         drop_d = out_q - CW'(imem_rvalid_i);
    else if (imem_rvalid_i && drop_q != '0) drop_d = drop_q - CW'(1);

    cnt_d = redirect_i ? '0 : cnt_q + CW'(push) - CW'(pop);
    wr_d  = redirect_i ? '0 : wr_q + PW'(push);
    rd_d  = redirect_i ? '0 : rd_q + PW'(pop);
    fwr_d = fwr_q + PW'(issue);
    frd_d = frd_q + PW'(imem_rvalid_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q   <= RESET_PC;
      cnt_q  <= '0;
      out_q  <= '0;
      drop_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      fwr_q  <= '0;
      frd_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      fwr_q  <= fwr_d;
      frd_q  <= frd_d;
    end
  end

  // Storage needs no reset: outputs are gated by the FIFO count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem_q[wr_q] <= imem_rdata_i;
      ipc_mem_q[wr_q]   <= fpc_mem_q[frd_q];
    end
    if (issue) fpc_mem_q[fwr_q] <= pc_q;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && cnt_q == CW'(DEPTH)));
  a_no_stray_rsp: assert property (@(posedge clk_i) disable iff (rst_i)
    !(imem_rvalid_i && out_q == '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order variable-latency memory model plus an
// expected-instruction-stream model (next fetch PC / next delivered PC).
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        redirect_i;
  logic [1:0]  redirect_mode_i;
  logic [31:0] redirect_base_i;
  logic [25:0] redirect_imm_i;
  logic [31:0] redirect_reg_i;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4), .RESET_PC(RPC)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .redirect_i(redirect_i), .redirect_mode_i(redirect_mode_i),
    .redirect_base_i(redirect_base_i), .redirect_imm_i(redirect_imm_i),
    .redirect_reg_i(redirect_reg_i)
  );

  typedef struct { logic [31:0] addr; int due; } req_t;
  req_t mq[$];
  int   tests = 0, fails = 0, cyc = 0, last_due = 0;
  int   lat_lo = 1, lat_hi = 1;
  int   nreq = 0, npop = 0, nreq0 = 0, found = 0;
  logic [31:0] nxt_req, nxt_exp;
  logic        s_req, s_valid, s_rvalid, s_pop;
  logic [31:0] s_addr, s_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Target rules: branch = pc+4 + imm16*4 (signed), jump = pc+4 top nibble | idx*4, reg = aligned reg.
  function automatic logic [31:0] model_tgt(input logic [1:0] m, input logic [31:0] base,
                                            input logic [25:0] imm, input logic [31:0] r);
    logic [31:0] pc4;
    int          off;
    pc4 = base + 32'd4;
    off = int'($signed(imm[15:0])) * 4;
    case (m)
      2'd0:    return pc4 + 32'(off);
      2'd1:    return (pc4 & 32'hF000_0000) + ({6'd0, imm} * 32'd4);
      default: return (r / 32'd4) * 32'd4;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: entered just after a falling edge, leaves at the next falling edge.
  task automatic step();
    req_t r;
    int   lat;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    #1;
    s_req = imem_req_o; s_addr = imem_addr_o; s_valid = instr_valid_o;
    s_pc = instr_pc_o; s_rvalid = imem_rvalid_i; s_pop = instr_valid_o && instr_ready_i;
    if (redirect_i) check("no_req_on_redirect", 32'(imem_req_o), 32'd0);
    if (imem_req_o) begin
      check("req_addr", imem_addr_o, nxt_req);
      lat    = $urandom_range(lat_hi, lat_lo);
      r.addr = imem_addr_o;
      r.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      last_due = r.due;
      mq.push_back(r);
      nxt_req += 32'd4;
      nreq++;
    end
    if (s_pop) begin
      check("pop_pc", instr_pc_o, nxt_exp);
      check("pop_instr", instr_o, mem_word(nxt_exp));
      nxt_exp += 32'd4;
      npop++;
    end
    if (redirect_i) begin
      nxt_req = model_tgt(redirect_mode_i, redirect_base_i, redirect_imm_i, redirect_reg_i);
      nxt_exp = nxt_req;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_redirect(input logic [1:0] m, input logic [31:0] b,
                             input logic [25:0] imm, input logic [31:0] r);
    redirect_i = 1'b1; redirect_mode_i = m; redirect_base_i = b;
    redirect_imm_i = imm; redirect_reg_i = r;
    step();
    redirect_i = 1'b0;
  endtask

  task automatic hold_reset(input int n);
    rst = 1'b1;
    imem_rvalid_i = 1'b0;
    mq.delete();
    last_due = 0;
    nxt_req = RPC;
    nxt_exp = RPC;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(imem_req_o),    32'd0);
    check({tag, "_addr"},  imem_addr_o,        RPC);
    check({tag, "_valid"}, 32'(instr_valid_o), 32'd0);
    check({tag, "_instr"}, instr_o,            32'd0);
    check({tag, "_pc"},    instr_pc_o,         32'd0);
  endtask

  initial begin
    rst = 1'b1; instr_ready_i = 1'b0; redirect_i = 1'b0; redirect_mode_i = 2'd0;
    redirect_base_i = '0; redirect_imm_i = '0; redirect_reg_i = '0;
    imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    #1;
    check_reset_outputs("rst");
    hold_reset(3);

    // Fill latency and address wrap from RESET_PC
    instr_ready_i = 1'b1; lat_lo = 1; lat_hi = 1;
    step();
    check("c1_req", 32'(s_req), 32'd1);
    check("c1_addr", s_addr, RPC);
    check("c1_valid", 32'(s_valid), 32'd0);
    step();
    check("c2_addr", s_addr, 32'hFFFF_FFFC);
    check("c2_valid", 32'(s_valid), 32'd0);
    step();
    check("c3_wrap_addr", s_addr, 32'h0000_0000);
    check("c3_valid", 32'(s_valid), 32'd1);
    check("c3_pc", s_pc, RPC);
    repeat (5) step();

    // Decode stalled: credits limit outstanding work to DEPTH
    instr_ready_i = 1'b0;
    do_redirect(2'd2, 32'h0, 26'h0, 32'h0000_0400);
    nreq0 = nreq;
    repeat (10) step();
    check("stall_reqs", 32'(nreq - nreq0), 32'd4);
    check("stall_req_low", 32'(s_req), 32'd0);
    check("stall_valid", 32'(s_valid), 32'd1);
    instr_ready_i = 1'b1;
    nreq0 = nreq;
    repeat (8) step();
    check("resume_reqs", 32'(nreq - nreq0), 32'd7);

    // Jump and register targets, request in the cycle after redirect
    do_redirect(2'd1, 32'h3000_0010, 26'h0000040, 32'h0);
    step();
    check("jump_req", 32'(s_req), 32'd1);
    check("jump_addr", s_addr, 32'h3000_0100);
    repeat (4) step();
    do_redirect(2'd2, 32'h0000_7770, 26'h0, 32'h0000_0123);
    step();
    check("reg_req", 32'(s_req), 32'd1);
    check("reg_addr", s_addr, 32'h0000_0120);
    repeat (4) step();

    // Redirect coinciding with a response and a pop
    do_redirect(2'd1, 32'h0000_1000, 26'h0000100, 32'h0);
    check("rdr_rsp", 32'(s_rvalid), 32'd1);
    check("rdr_pop", 32'(s_pop), 32'd1);
    step();
    check("rdr_empty", 32'(s_valid), 32'd0);
    repeat (6) step();

    // Backward branch with 3-cycle memory: stale responses must vanish
    lat_lo = 3; lat_hi = 3;
    repeat (12) step();
    do_redirect(2'd0, 32'h0000_0200, 26'h000FFFE, 32'h0);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      step();
      if (s_req) begin
        found = 1;
        check("br_addr", s_addr, 32'h0000_01FC);
      end
    end
    check("br_req_seen", 32'(found), 32'd1);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step();
      if (s_valid) begin
        found = 1;
        check("br_first_pc", s_pc, 32'h0000_01FC);
      end
    end
    check("br_valid_seen", 32'(found), 32'd1);

    // Randomized traffic: variable latency, ready and redirects
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 400; i++) begin
      instr_ready_i = ($urandom_range(3, 0) != 0);
      if ($urandom_range(15, 0) == 0)
        do_redirect(2'($urandom), $urandom & 32'hFFFF_FFFC, 26'($urandom), $urandom);
      else
        step();
    end
    instr_ready_i = 1'b1; lat_lo = 1; lat_hi = 1;
    repeat (20) step();
    check("rand_progress", 32'(npop > 100), 32'd1);

    // Asynchronous reset in the middle of a cycle
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async");
    hold_reset(2);
    step();
    check("post_rst_addr", s_addr, RPC);
    repeat (6) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
